ps2_note_tracker: RTL

Turns the raw PS/2 byte stream from `PS2_Controller` (`received_data` / `received_data_en`) into a held-key bitmap and a single current note for the flute voice. It decodes PS/2 Set-2 make, break (`F0`) and extended (`E0`) sequences for the eight note keys, and arbitrates between simultaneously held keys: the most recently pressed key wins. The space key is a global silence. It sits between `PS2_Controller` and the tone generator / HEX / LEDR display logic, and replaces the ad-hoc last-byte latch.

---
 rtl/flute_pkg.sv | 50 +++++
 rtl/ps2_seq_decoder.sv | 67 ++++++
 rtl/ps2_note_tracker.sv | 108 ++++++++++
 3 files changed

// File: rtl/flute_pkg.sv
// rtl/flute_pkg.sv - shared scan codes, note index type and lookup for the flute voice
package flute_pkg;

    localparam int NUM_NOTES = 8;

    localparam logic [7:0] SC_C     = 8'h16;
    localparam logic [7:0] SC_D     = 8'h1E;
    localparam logic [7:0] SC_E     = 8'h26;
    localparam logic [7:0] SC_F     = 8'h25;
    localparam logic [7:0] SC_G     = 8'h2E;
    localparam logic [7:0] SC_A     = 8'h36;
    localparam logic [7:0] SC_B     = 8'h3D;
    localparam logic [7:0] SC_C_HI  = 8'h3E;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef logic [2:0] note_idx_t;

    typedef struct packed {
        logic      valid;
        note_idx_t idx;
    } note_lookup_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } seq_state_t;

    function automatic note_lookup_t code_to_index(input logic [7:0] code);
        note_lookup_t r;
        r.valid = 1'b1;
        r.idx   = 3'd0;
        case (code)
            SC_C:    r.idx = 3'd0;
            SC_D:    r.idx = 3'd1;
            SC_E:    r.idx = 3'd2;
            SC_F:    r.idx = 3'd3;
            SC_G:    r.idx = 3'd4;
            SC_A:    r.idx = 3'd5;
            SC_B:    r.idx = 3'd6;
            SC_C_HI: r.idx = 3'd7;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_seq_decoder.sv
// rtl/ps2_seq_decoder.sv - PS/2 Set-2 prefix FSM with idle timeout, emits one event per code byte
module ps2_seq_decoder
    import flute_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    output logic [7:0] o_code,
    output logic       o_is_break,
    output logic       o_is_ext,
    output logic       o_valid
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic          w_expire;

    assign w_expire = (r_state != ST_IDLE) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Counter holds at zero in IDLE and restarts on every byte
            if (i_data_en || r_state == ST_IDLE || w_expire)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_code     = i_data;
        o_valid    = 1'b0;
        o_is_break = 1'b0;
        o_is_ext   = 1'b0;
        if (i_data_en) begin
            if (i_data == SC_EXT) begin
                w_next = ST_EXT;
            end else if (i_data == SC_BREAK) begin
                case (r_state)
                    ST_IDLE: w_next = ST_BRK;
                    ST_EXT:  w_next = ST_EXT_BRK;
                    default: w_next = r_state;
                endcase
            end else begin
                o_valid    = 1'b1;
                o_is_break = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
                o_is_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
                w_next     = ST_IDLE;
            end
        end else if (w_expire) begin
            w_next = ST_IDLE;
        end
    end

endmodule

// File: rtl/ps2_note_tracker.sv
// rtl/ps2_note_tracker.sv - held-key bitmap and last-pressed-wins note arbitration for PS/2 input
module ps2_note_tracker
    import flute_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] key_held,
    output logic       note_active,
    output logic [2:0] note_index,
    output logic       note_change
);

    logic [7:0]   w_code;
    logic         w_ev_break;
    logic         w_ev_ext;
    logic         w_ev_valid;
    note_lookup_t w_lookup;
    logic [7:0]   w_bit;
    logic [7:0]   w_held_clr;
    logic         w_fb_valid;
    note_idx_t    w_fb_idx;

    logic [7:0]   r_key_held;
    logic         r_note_active;
    note_idx_t    r_note_index;
    logic         r_note_change;
    logic [7:0]   w_held_n;
    logic         w_active_n;
    note_idx_t    w_idx_n;

    ps2_seq_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dec (
        .i_clk      (CLOCK_50),
        .i_reset    (reset),
        .i_data     (received_data),
        .i_data_en  (received_data_en),
        .o_code     (w_code),
        .o_is_break (w_ev_break),
        .o_is_ext   (w_ev_ext),
        .o_valid    (w_ev_valid)
    );

    assign w_lookup   = code_to_index(w_code);
    assign w_bit      = 8'd1 << w_lookup.idx;
    assign w_held_clr = r_key_held & ~w_bit;

    // Fallback after releasing the current note: lowest index still held
    always_comb begin
        w_fb_valid = 1'b0;
        w_fb_idx   = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (w_held_clr[i]) begin
                w_fb_valid = 1'b1;
                w_fb_idx   = note_idx_t'(i);
            end
        end
    end

    always_comb begin
        w_held_n   = r_key_held;
        w_active_n = r_note_active;
        w_idx_n    = r_note_index;
        if (w_ev_valid && !w_ev_ext) begin
            if (!w_ev_break) begin
                if (w_lookup.valid) begin
                    w_held_n   = r_key_held | w_bit;
                    w_active_n = 1'b1;
                    w_idx_n    = w_lookup.idx;
                end else if (w_code == SC_SPACE) begin
                    w_held_n   = '0;
                    w_active_n = 1'b0;
                    w_idx_n    = '0;
                end
            end else if (w_lookup.valid && (|(r_key_held & w_bit))) begin
                w_held_n = w_held_clr;
                if (r_note_index == w_lookup.idx) begin
                    w_active_n = w_fb_valid;
                    w_idx_n    = w_fb_idx;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_key_held    <= '0;
            r_note_active <= 1'b0;
            r_note_index  <= '0;
            r_note_change <= 1'b0;
        end else begin
            r_key_held    <= w_held_n;
            r_note_active <= w_active_n;
            r_note_index  <= w_idx_n;
            r_note_change <= (w_active_n != r_note_active) || (w_idx_n != r_note_index);
        end
    end

    assign key_held    = r_key_held;
    assign note_active = r_note_active;
    assign note_index  = r_note_index;
    assign note_change = r_note_change;

endmodule
